// File: rtl/inst_fetch_arb_pkg.sv
// Shared constants and owner-state encoding for the instruction ROM arbiter.
`timescale 1ns/1ps
package inst_fetch_arb_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 32;

    localparam logic [INST_W-1:0] ZERO_WORD    = 32'h0000_0000;
    localparam logic              CHIP_ENABLE  = 1'b1;
    localparam logic              CHIP_DISABLE = 1'b0;

    // Owner of the ROM access launched in the previous cycle.
    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_IF   = 2'b01,
        ARB_DBG  = 2'b10
    } arb_state_e;

    function automatic arb_state_e next_owner(input logic if_gnt, input logic dbg_gnt);
        if (if_gnt) begin
            return ARB_IF;
        end else if (dbg_gnt) begin
            return ARB_DBG;
        end
        return ARB_IDLE;
    endfunction

endpackage

// File: rtl/inst_fetch_arb_wait_cnt.sv
// Saturating count of consecutive cycles the debug port was refused the ROM.
`timescale 1ns/1ps
module arb_wait_cnt #(
    parameter int MAX_WAIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dbg_req,
    input  logic       dbg_gnt,
    output logic [3:0] cnt,
    output logic       at_max
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!dbg_req || dbg_gnt) begin
            cnt_d = 4'd0;
        end else if (cnt_q != MAX_CNT) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt    = cnt_q;
    assign at_max = (cnt_q == MAX_CNT);

endmodule

// File: rtl/inst_fetch_arb.sv
// Shares the single-port instruction ROM between fetch and the debug reader,
// registering the returned word onto the port that owned the access.
`timescale 1ns/1ps
module inst_fetch_arb
    import inst_fetch_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        dbg_req,
    input  logic [31:0] dbg_addr,
    output logic        dbg_gnt,
    output logic        dbg_rvalid,
    output logic [31:0] dbg_rdata,
    output logic        rom_ce,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_inst,
    output logic        stallreq
);

    // Handshake: a requester holds req/addr stable until it samples gnt=1 in
    // the same cycle; the word for that grant is presented with rvalid=1 in the
    // following cycle, and req/addr may change in that cycle.

    arb_state_e  state_q, state_d;
    logic        if_rvalid_q, if_rvalid_d;
    logic        dbg_rvalid_q, dbg_rvalid_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] dbg_rdata_q, dbg_rdata_d;
    logic [3:0]  wait_cnt;
    logic        wait_at_max;

    arb_wait_cnt #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_cnt (
        .clk     (clk),
        .rst     (rst),
        .dbg_req (dbg_req),
        .dbg_gnt (dbg_gnt),
        .cnt     (wait_cnt),
        .at_max  (wait_at_max)
    );

    always_comb begin
        // Fetch owns the port unless it is idle or debug has waited its limit.
        dbg_gnt  = dbg_req && (!if_req || wait_at_max);
        if_gnt   = if_req && !dbg_gnt;
        stallreq = if_req && !if_gnt;
        rom_ce   = (if_gnt || dbg_gnt) ? CHIP_ENABLE : CHIP_DISABLE;
        rom_addr = ZERO_WORD;
        if (if_gnt) begin
            rom_addr = if_addr;
        end else if (dbg_gnt) begin
            rom_addr = dbg_addr;
        end

        state_d      = next_owner(if_gnt, dbg_gnt);
        if_rvalid_d  = (state_d == ARB_IF);
        dbg_rvalid_d = (state_d == ARB_DBG);
        if_rdata_d   = if_rvalid_d ? rom_inst : if_rdata_q;
        dbg_rdata_d  = dbg_rvalid_d ? rom_inst : dbg_rdata_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            if_rvalid_q  <= 1'b0;
            dbg_rvalid_q <= 1'b0;
            if_rdata_q   <= ZERO_WORD;
            dbg_rdata_q  <= ZERO_WORD;
        end else begin
            state_q      <= state_d;
            if_rvalid_q  <= if_rvalid_d;
            dbg_rvalid_q <= dbg_rvalid_d;
            if_rdata_q   <= if_rdata_d;
            dbg_rdata_q  <= dbg_rdata_d;
        end
    end

    assign if_rvalid  = if_rvalid_q;
    assign if_rdata   = if_rdata_q;
    assign dbg_rvalid = dbg_rvalid_q;
    assign dbg_rdata  = dbg_rdata_q;

endmodule

// File: tb/tb_inst_fetch_arb.sv
// Bench for inst_fetch_arb: a ROM model, a per-cycle reference model and
// directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_inst_fetch_arb;
    import inst_fetch_arb_pkg::*;

    localparam int MAX_WAIT = 4;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, dbg_req;
    logic [31:0] if_addr, dbg_addr;
    logic        if_gnt, if_rvalid, dbg_gnt, dbg_rvalid, rom_ce, stallreq;
    logic [31:0] if_rdata, dbg_rdata, rom_addr, rom_inst;

    always #5 clk = ~clk;

    inst_fetch_arb #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .dbg_req    (dbg_req),
        .dbg_addr   (dbg_addr),
        .dbg_gnt    (dbg_gnt),
        .dbg_rvalid (dbg_rvalid),
        .dbg_rdata  (dbg_rdata),
        .rom_ce     (rom_ce),
        .rom_addr   (rom_addr),
        .rom_inst   (rom_inst),
        .stallreq   (stallreq)
    );

    // ---------------- ROM model ----------------
    logic [31:0] rom_mem [32];
    initial begin
        for (int i = 0; i < 32; i++) rom_mem[i] = 32'h1000_0000 | i;
        rom_mem[1] = 32'h3401_1100;
        rom_mem[4] = 32'h8C01_0010;
    end
    assign rom_inst = rom_mem[rom_addr[6:2]];

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return rom_mem[a[6:2]];
    endfunction

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: debug may use the ROM whenever fetch is idle, or once it
    // has already been refused MAX_WAIT times in a row; the owner's word shows
    // up one cycle later and the other port keeps its last word.
    int          m_refused = 0;
    logic        m_if_rv = 1'b0, m_dbg_rv = 1'b0;
    logic [31:0] m_if_rd = 32'h0, m_dbg_rd = 32'h0;

    always @(negedge clk) begin
        logic e_dbg, e_if;
        logic [31:0] e_addr;
        if (rst) begin
            m_refused = 0;
            m_if_rv = 1'b0; m_dbg_rv = 1'b0;
            m_if_rd = 32'h0; m_dbg_rd = 32'h0;
            check("rst_if_rvalid",  {31'b0, if_rvalid},  32'(m_if_rv));
            check("rst_dbg_rvalid", {31'b0, dbg_rvalid}, 32'(m_dbg_rv));
            check("rst_if_rdata",   if_rdata,  m_if_rd);
            check("rst_dbg_rdata",  dbg_rdata, m_dbg_rd);
        end else begin
            e_dbg  = dbg_req && (!if_req || m_refused >= MAX_WAIT);
            e_if   = if_req && !e_dbg;
            e_addr = e_if ? if_addr : (e_dbg ? dbg_addr : 32'h0);
            check("if_gnt",     {31'b0, if_gnt},     32'(e_if));
            check("dbg_gnt",    {31'b0, dbg_gnt},    32'(e_dbg));
            check("rom_ce",     {31'b0, rom_ce},     32'(e_if || e_dbg));
            check("rom_addr",   rom_addr, e_addr);
            check("stallreq",   {31'b0, stallreq},   32'(if_req && !e_if));
            check("if_rvalid",  {31'b0, if_rvalid},  32'(m_if_rv));
            check("dbg_rvalid", {31'b0, dbg_rvalid}, 32'(m_dbg_rv));
            check("if_rdata",   if_rdata,  m_if_rd);
            check("dbg_rdata",  dbg_rdata, m_dbg_rd);
            m_if_rv  = e_if;
            m_dbg_rv = e_dbg;
            if (e_if)  m_if_rd  = rom_word(if_addr);
            if (e_dbg) m_dbg_rd = rom_word(dbg_addr);
            if (dbg_req && !e_dbg) m_refused = (m_refused < MAX_WAIT) ? m_refused + 1 : MAX_WAIT;
            else m_refused = 0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic [31:0] da);
        if_req = ir; if_addr = ia; dbg_req = dr; dbg_addr = da;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        repeat (2) @(negedge clk);
        check("reset_state", 32'(dut.state_q), 32'(ARB_IDLE));
        check("reset_wait",  32'(dut.wait_cnt), 32'd0);
        step();
        rst = 1'b0;
        step();

        // single fetch
        drive(1'b1, 32'h0000_0004, 1'b0, 32'h0);
        @(negedge clk);
        check("t1_if_gnt",   {31'b0, if_gnt}, 32'd1);
        check("t1_rom_addr", rom_addr, 32'h0000_0004);
        step();
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        check("t1_if_rvalid", {31'b0, if_rvalid}, 32'd1);
        check("t1_if_rdata",  if_rdata, 32'h3401_1100);
        step();

        // continuous fetch, debug forced in on its 5th requesting cycle
        drive(1'b1, 32'h0000_0008, 1'b1, 32'h0000_0010);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t2_dbg_gnt",  {31'b0, dbg_gnt},  32'(i == 4));
            check("t2_stallreq", {31'b0, stallreq}, 32'(i == 4));
            step();
        end
        drive(1'b1, 32'h0000_0008, 1'b0, 32'h0);
        @(negedge clk);
        check("t2_dbg_rvalid", {31'b0, dbg_rvalid}, 32'd1);
        check("t2_dbg_rdata",  dbg_rdata, 32'h8C01_0010);
        check("t2_if_resume",  {31'b0, if_gnt}, 32'd1);
        step();
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        step();

        // debug streaming while fetch is idle
        for (int i = 0; i < 4; i++) begin
            logic [31:0] words [3];
            words[0] = 32'h1000_0000; words[1] = 32'h3401_1100; words[2] = 32'h1000_0002;
            if (i < 3) drive(1'b0, 32'h0, 1'b1, 32'(4 * i));
            else       drive(1'b0, 32'h0, 1'b0, 32'h0);
            @(negedge clk);
            if (i < 3) check("t3_dbg_gnt", {31'b0, dbg_gnt}, 32'd1);
            if (i > 0) begin
                check("t3_dbg_rvalid", {31'b0, dbg_rvalid}, 32'd1);
                check("t3_dbg_rdata",  dbg_rdata, words[i-1]);
            end
            check("t3_wait", 32'(dut.wait_cnt), 32'd0);
            step();
        end

        // alternating ownership IF, DBG, IF
        drive(1'b1, 32'h0000_000C, 1'b0, 32'h0);
        step();
        drive(1'b0, 32'h0, 1'b1, 32'h0000_0014);
        @(negedge clk);
        check("t4_if_rvalid",  {31'b0, if_rvalid},  32'd1);
        check("t4_dbg_rvalid", {31'b0, dbg_rvalid}, 32'd0);
        check("t4_dbg_hold",   dbg_rdata, 32'h1000_0002);
        step();
        drive(1'b1, 32'h0000_0018, 1'b0, 32'h0);
        @(negedge clk);
        check("t4_dbg_rdata",  dbg_rdata, 32'h1000_0005);
        check("t4_if_rvalid0", {31'b0, if_rvalid}, 32'd0);
        check("t4_if_hold",    if_rdata, 32'h1000_0003);
        step();
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        check("t4_if_rdata",   if_rdata, 32'h1000_0006);
        check("t4_dbg_hold2",  dbg_rdata, 32'h1000_0005);
        step();

        // asynchronous reset right after a grant
        drive(1'b1, 32'h0000_001C, 1'b0, 32'h0);
        step();
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        #2;
        check("t5_rvalid_pre", {31'b0, if_rvalid}, 32'd1);
        rst = 1'b1;
        #1;
        check("t5_rvalid_cut", {31'b0, if_rvalid}, 32'd0);
        check("t5_rdata_cut",  if_rdata, 32'h0);
        check("t5_state_idle", 32'(dut.state_q), 32'(ARB_IDLE));
        step();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("t5_no_resp", {31'b0, if_rvalid | dbg_rvalid}, 32'd0);
            step();
        end

        // simultaneous first requests
        drive(1'b1, 32'h0000_0020, 1'b1, 32'h0000_0024);
        @(negedge clk);
        check("t6_if_gnt",   {31'b0, if_gnt},   32'd1);
        check("t6_dbg_gnt",  {31'b0, dbg_gnt},  32'd0);
        check("t6_rom_ce",   {31'b0, rom_ce},   32'd1);
        check("t6_stallreq", {31'b0, stallreq}, 32'd0);
        step();
        @(negedge clk);
        check("t6_wait", 32'(dut.wait_cnt), 32'd1);
        step();

        // debug gives up before being granted: no response may appear
        drive(1'b1, 32'h0000_0028, 1'b0, 32'h0);
        step();
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
